// File: rtl/memcompose_pkg.sv
// Shared definitions for the SRAM port initiator slice.
//   MEM_CSB_IDLE / MEM_WEB_IDLE : macro control levels when no access is issued
//   clog2                       : ceiling log2 for sizing counters and pointers
package memcompose_pkg;

  localparam logic MEM_CSB_IDLE = 1'b1;
  localparam logic MEM_WEB_IDLE = 1'b1;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO holding captured read data until the consumer takes it.
//   clk, rst_n : clock and synchronous active-low reset (empties the FIFO)
//   push, din  : write one entry
//   pop        : drop the head entry
//   dout       : head entry (stable until popped)
//   empty, full: occupancy status
module rsp_fifo
  import memcompose_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
  endfunction

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign do_pop_s  = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; data contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rsp_fifo_chk.sv
// Protocol checker for the response FIFO.
//   clk, rst_n : clock and synchronous active-low reset
//   push, pop  : FIFO write / read strobes as seen by the FIFO
//   empty, full: FIFO status
module rsp_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic empty,
  input logic full
);

  // A capture must always find a free slot (credit scheme guarantees it).
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

  // The consumer side only pops while data is presented.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));

endmodule

// File: rtl/sram_port_initiator.sv
// Request-side initiator for a single-port (1RW) synchronous SRAM macro.
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/req_ready    : request handshake; req_we selects write
//   req_addr, req_wdata    : request address and write data
//   rsp_valid/rsp_ready    : in-order read response handshake, data rsp_rdata
//   mem_csb/web/addr/din   : macro inputs (active-low select and write enable)
//   mem_dout               : macro read data, valid RD_LAT cycles after sampling
//   busy                   : a read is in flight or buffered
module sram_port_initiator
  import memcompose_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int CNT_W = clog2(RSP_DEPTH + 1);

  logic [CNT_W-1:0]  cnt_r;          // reads in flight + FIFO occupancy
  logic [RD_LAT-1:0] rd_pipe_r;      // bit k set: read issued k+1 cycles ago
  logic [ADDR_W-1:0] addr_shadow_r;
  logic [DATA_W-1:0] din_shadow_r;
  logic              fire_s;
  logic              read_fire_s;
  logic              rsp_pop_s;
  logic              capture_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;

  // Every accepted read owns a FIFO slot up front, so capture never overflows.
  assign req_ready   = (cnt_r < CNT_W'(RSP_DEPTH));
  assign fire_s      = req_valid & req_ready;
  assign read_fire_s = fire_s & ~req_we;
  assign rsp_valid   = ~fifo_empty_s;
  assign rsp_pop_s   = rsp_valid & rsp_ready;
  assign capture_s   = rd_pipe_r[RD_LAT-1];
  assign busy        = (cnt_r != {CNT_W{1'b0}});

  // Macro port drive: live request when firing, otherwise hold last values.
  always_comb begin
    mem_csb  = MEM_CSB_IDLE;
    mem_web  = MEM_WEB_IDLE;
    mem_addr = addr_shadow_r;
    mem_din  = din_shadow_r;
    if (fire_s) begin
      mem_csb  = 1'b0;
      mem_web  = ~req_we;
      mem_addr = req_addr;
      mem_din  = req_wdata;
    end else begin
      mem_csb  = MEM_CSB_IDLE;
      mem_web  = MEM_WEB_IDLE;
      mem_addr = addr_shadow_r;
      mem_din  = din_shadow_r;
    end
  end

  // Shadow of the last issued address/data keeps macro inputs quiet when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_shadow_r <= {ADDR_W{1'b0}};
      din_shadow_r  <= {DATA_W{1'b0}};
    end else if (fire_s) begin
      addr_shadow_r <= req_addr;
      din_shadow_r  <= req_wdata;
    end else begin
      addr_shadow_r <= addr_shadow_r;
      din_shadow_r  <= din_shadow_r;
    end
  end

  // Read latency tracker; clearing it on reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe_r <= {RD_LAT{1'b0}};
    end else begin
      rd_pipe_r[0] <= read_fire_s;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  // Credit counter: a read takes a credit, a response pop returns it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      case ({read_fire_s, rsp_pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture_s),
    .pop   (rsp_pop_s),
    .din   (mem_dout),
    .dout  (rsp_rdata),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  rsp_fifo_chk u_rsp_fifo_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture_s),
    .pop   (rsp_pop_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

endmodule

// File: tb/tb_sram_port_initiator.sv
// Bench for sram_port_initiator: instance a (RD_LAT=1) and instance b (RD_LAT=2),
// each attached to a small behavioural 1RW macro. A scoreboard queue per
// instance holds expected read data and issue cycle.
module tb_sram_port_initiator;

  localparam int AW = 10;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
    bit            lc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic garbage = 1'b0;
  bit   lat_chk = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
  logic          a_mem_csb, a_mem_web, a_busy;
  logic [AW-1:0] a_req_addr, a_mem_addr;
  logic [DW-1:0] a_req_wdata, a_rsp_rdata, a_mem_din, a_mem_dout, a_st1;
  logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
  logic          b_mem_csb, b_mem_web, b_busy;
  logic [AW-1:0] b_req_addr, b_mem_addr;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata, b_mem_din, b_mem_dout, b_st1, b_st2;

  logic [DW-1:0] mema [1024];
  logic [DW-1:0] memb [1024];
  logic [DW-1:0] refa [1024];
  logic [DW-1:0] refb [1024];
  exp_t qa[$];
  exp_t qb[$];
  int   a_run = 0, a_maxrun = 0, b_run = 0, b_maxrun = 0;
  logic [DW-1:0] a_last = 16'h0000;

  sram_port_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .RSP_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .mem_csb(a_mem_csb), .mem_web(a_mem_web), .mem_addr(a_mem_addr),
    .mem_din(a_mem_din), .mem_dout(a_mem_dout), .busy(a_busy));

  sram_port_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .RSP_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .mem_csb(b_mem_csb), .mem_web(b_mem_web), .mem_addr(b_mem_addr),
    .mem_din(b_mem_din), .mem_dout(b_mem_dout), .busy(b_busy));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural macro a: one-cycle read latency.
  always @(posedge clk) begin
    if (!a_mem_csb) begin
      if (!a_mem_web) mema[a_mem_addr] <= a_mem_din;
      else            a_st1 <= mema[a_mem_addr];
    end
  end
  assign a_mem_dout = garbage ? 16'hDEAD : a_st1;

  // Behavioural macro b: two-cycle read latency.
  always @(posedge clk) begin
    if (!b_mem_csb) begin
      if (!b_mem_web) memb[b_mem_addr] <= b_mem_din;
      else            b_st1 <= memb[b_mem_addr];
    end
    b_st2 <= b_st1;
  end
  assign b_mem_dout = b_st2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard for instance a.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      qa.delete();
      a_run = 0;
    end else begin
      if (a_rsp_valid && a_rsp_ready) begin
        if (qa.size() == 0) check_eq("a_spurious_rsp", {16'h0000, a_rsp_rdata}, 32'h0);
        else begin
          e = qa.pop_front();
          a_last = a_rsp_rdata;
          check_eq("a_rdata", {16'h0000, a_rsp_rdata}, {16'h0000, e.d});
          if (e.lc) check_eq("a_latency", cyc - e.c, 32'd2);
        end
      end
      if (a_req_valid && a_req_ready) begin
        if (a_req_we) refa[a_req_addr] = a_req_wdata;
        else qa.push_back('{d: refa[a_req_addr], c: cyc, lc: lat_chk});
      end
      if (a_rsp_valid) a_run = a_run + 1; else a_run = 0;
      if (a_run > a_maxrun) a_maxrun = a_run;
    end
  end

  // Scoreboard for instance b.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      qb.delete();
      b_run = 0;
    end else begin
      if (b_rsp_valid && b_rsp_ready) begin
        if (qb.size() == 0) check_eq("b_spurious_rsp", {16'h0000, b_rsp_rdata}, 32'h0);
        else begin
          e = qb.pop_front();
          check_eq("b_rdata", {16'h0000, b_rsp_rdata}, {16'h0000, e.d});
          if (e.lc) check_eq("b_latency", cyc - e.c, 32'd3);
        end
      end
      if (b_req_valid && b_req_ready) begin
        if (b_req_we) refb[b_req_addr] = b_req_wdata;
        else qb.push_back('{d: refb[b_req_addr], c: cyc, lc: lat_chk});
      end
      if (b_rsp_valid) b_run = b_run + 1; else b_run = 0;
      if (b_run > b_maxrun) b_maxrun = b_run;
    end
  end

  // One request cycle on instance a (inst=0) or b (inst=1); ready must be high.
  task automatic issue(input bit inst, input logic we, input int addr, input logic [DW-1:0] data, input string tag);
    @(posedge clk); #1;
    if (inst) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = AW'(addr); b_req_wdata = data;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = AW'(addr); a_req_wdata = data;
    end
    @(negedge clk);
    check_eq(tag, {31'h0, inst ? b_req_ready : a_req_ready}, 32'h1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (a_busy || b_busy || qa.size() != 0 || qb.size() != 0); i++)
      @(negedge clk);
    check_eq({tag, "_pending"}, qa.size() + qb.size(), 32'h0);
    check_eq({tag, "_busy"}, {30'h0, a_busy, b_busy}, 32'h0);
  endtask

  initial begin
    int acc;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    check_eq("rst_busy", {30'h0, a_busy, b_busy}, 32'h0);
    check_eq("rst_req_ready", {30'h0, a_req_ready, b_req_ready}, 32'h3);
    check_eq("rst_csb_web", {28'h0, a_mem_csb, a_mem_web, b_mem_csb, b_mem_web}, 32'hF);
    check_eq("rst_mem_addr", {22'h0, a_mem_addr}, 32'h0);
    check_eq("rst_mem_din", {16'h0, a_mem_din}, 32'h0);

    // 1: write then read back
    issue(1'b0, 1'b1, 32'h005, 16'hBEEF, "t1_wr_ready");
    check_eq("t1_web_active", {30'h0, a_mem_csb, a_mem_web}, 32'h0);
    check_eq("t1_din", {16'h0, a_mem_din}, 32'hBEEF);
    idle();
    @(negedge clk);
    check_eq("t1_web_idle", {30'h0, a_mem_csb, a_mem_web}, 32'h3);
    check_eq("t1_addr_hold", {22'h0, a_mem_addr}, 32'h005);
    check_eq("t1_din_hold", {16'h0, a_mem_din}, 32'hBEEF);
    issue(1'b0, 1'b0, 32'h005, 16'h0000, "t1_rd_ready");
    idle();
    drain("t1");

    // 2: preload 0..7, then eight back-to-back reads
    for (int i = 0; i < 8; i++) issue(1'b0, 1'b1, i, DW'(i * 32'h1111), "t2_wr_ready");
    a_maxrun = 0;
    for (int i = 0; i < 8; i++) issue(1'b0, 1'b0, i, 16'h0000, "t2_rd_ready");
    idle();
    drain("t2");
    check_eq("t2_valid_run", a_maxrun, 32'd8);

    // 3: backpressure fills the credits
    lat_chk = 1'b0;
    a_rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = AW'(acc);
      @(negedge clk);
      if (a_req_ready) acc = acc + 1;
    end
    check_eq("t3_accepted", acc, 32'd4);
    check_eq("t3_ready_low", {31'h0, a_req_ready}, 32'h0);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_ready_at_pop", {30'h0, a_req_ready, a_rsp_valid}, 32'h1);
    @(negedge clk);
    check_eq("t3_ready_after_pop", {31'h0, a_req_ready}, 32'h1);
    drain("t3");
    lat_chk = 1'b1;

    // 4: read in the cycle after a write to the same address
    issue(1'b0, 1'b1, 32'h00A, 16'h5555, "t4_wr0_ready");
    issue(1'b0, 1'b1, 32'h00A, 16'h1234, "t4_wr1_ready");
    issue(1'b0, 1'b0, 32'h00A, 16'h0000, "t4_rd_ready");
    idle();
    drain("t4");
    check_eq("t4_raw_data", {16'h0, a_last}, 32'h1234);

    // 5: reset with reads outstanding, then garbage on mem_dout
    lat_chk = 1'b0;
    a_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 1'b0, i, 16'h0000, "t5_rd_ready");
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    garbage = 1'b1;
    a_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t5_no_rsp", {31'h0, a_rsp_valid}, 32'h0);
      check_eq("t5_idle", {30'h0, a_busy, a_req_ready}, 32'h1);
    end
    garbage = 1'b0;
    lat_chk = 1'b1;
    issue(1'b0, 1'b0, 7, 16'h0000, "t5_post_rd_ready");
    idle();
    drain("t5");
    check_eq("t5_post_data", {16'h0, a_last}, 32'h7777);

    // 6: RD_LAT=2 streaming
    for (int i = 0; i < 10; i++) issue(1'b1, 1'b1, 32'h20 + i, DW'(32'h0100 + i * 32'h0101), "t6_wr_ready");
    b_maxrun = 0;
    for (int i = 0; i < 10; i++) issue(1'b1, 1'b0, 32'h20 + i, 16'h0000, "t6_rd_ready");
    idle();
    drain("t6");
    check_eq("t6_valid_run", b_maxrun, 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    check_eq("watchdog_timeout", 32'h1, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
